// File: rtl/hdmi_period_scheduler.sv
// hdmi_period_scheduler: per-pixel HDMI period selection and data-island packet arbitration.
// Define HDMI_SCHED_RR_EN for round-robin among requesters 1..NUM_REQ-1 (index 0 stays strict priority).
module hdmi_period_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int ISLAND_START_X = 10,
  parameter int MAX_PACKETS = 18,
  parameter int CTRL_MIN = 12,
  localparam int SW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk_pix,
  input  logic               rst_in,
  input  logic [9:0]         cx,
  input  logic [9:0]         cy,
  input  logic [9:0]         screen_start_x,
  input  logic [9:0]         screen_start_y,
  input  logic [NUM_REQ-1:0] req,
  output logic [2:0]         mode,
  output logic [SW-1:0]      pkt_sel,
  output logic [4:0]         pkt_cnt,
  output logic [NUM_REQ-1:0] grant
);
  typedef enum logic [2:0] {IDLE, DI_PRE, DI_LEAD, DI_DATA, DI_TRAIL} state_t;
  localparam int OVH = ISLAND_START_X + 22 + CTRL_MIN;
  state_t state_q, state_d;
  logic [2:0] cnt_q, cnt_d, mode_d, vmode;
  logic [4:0] pkt_cnt_d, npkt_q, npkt_d;
  logic [SW-1:0] pkt_sel_d, nsel_q, nsel_d, win;
  logic [NUM_REQ-1:0] grant_d;
  logic have_q, have_d, found, arb, ok;
  logic signed [11:0] room, nm, n_max;
  logic [10:0] x, s;
`ifdef HDMI_SCHED_RR_EN
  logic [SW-1:0] rr_q, rr_d;
  int idx;
`endif
  // Packets that fit in the blanking before the video preamble, leaving CTRL_MIN of control.
  always_comb begin
    room = $signed({2'b0, screen_start_x}) - 12'(OVH);
    nm = room >>> 5;
    n_max = (nm > $signed(12'(MAX_PACKETS))) ? $signed(12'(MAX_PACKETS)) : nm;
    ok = $signed({7'b0, npkt_q}) < n_max;
  end
  always_comb begin
    found = 1'b0;
    win = '0;
`ifdef HDMI_SCHED_RR_EN
    idx = 1;
    for (int k = NUM_REQ - 2; k >= 0; k--) begin
      idx = 1 + (int'(rr_q) - 1 + k) % (NUM_REQ - 1);
      if (req[idx]) begin
        found = 1'b1;
        win = SW'(idx);
      end
    end
    if (req[0]) begin
      found = 1'b1;
      win = '0;
    end
`else
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        found = 1'b1;
        win = SW'(i);
      end
    end
`endif
    found = found && ok;
  end
  always_comb begin
    x = {1'b0, cx};
    s = {1'b0, screen_start_x};
    vmode = (cy < screen_start_y) ? 3'd0 : (x >= s) ? 3'd3 : (x + 11'd2 >= s) ? 3'd2 : (x + 11'd10 >= s) ? 3'd1 : 3'd0;
  end
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q + 3'd1;
    pkt_cnt_d = pkt_cnt;
    pkt_sel_d = pkt_sel;
    npkt_d = npkt_q;
    nsel_d = nsel_q;
    have_d = have_q;
    grant_d = '0;
    arb = 1'b0;
`ifdef HDMI_SCHED_RR_EN
    rr_d = rr_q;
`endif
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        npkt_d = '0;
        if (cx == 10'(ISLAND_START_X) && |req && n_max > 12'sd0) state_d = DI_PRE;
      end
      DI_PRE: if (cnt_q == 3'd7) begin
        state_d = DI_LEAD;
        cnt_d = '0;
      end
      DI_LEAD: if (cnt_q == 3'd0) arb = 1'b1;
      else begin
        // A leading guard always opens one packet, even if nobody won.
        state_d = DI_DATA;
        pkt_cnt_d = '0;
        pkt_sel_d = nsel_q;
        npkt_d = npkt_q + 5'd1;
      end
      DI_DATA: begin
        pkt_cnt_d = pkt_cnt + 5'd1;
        arb = pkt_cnt == 5'd30;
        if (pkt_cnt == 5'd31) begin
          if (have_q) begin
            pkt_sel_d = nsel_q;
            npkt_d = npkt_q + 5'd1;
          end else begin
            state_d = DI_TRAIL;
            cnt_d = '0;
            pkt_cnt_d = pkt_cnt;
          end
        end
      end
      DI_TRAIL: if (cnt_q == 3'd1) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (arb) begin
      have_d = found;
      if (found) begin
        nsel_d = win;
        grant_d = NUM_REQ'(1) << win;
`ifdef HDMI_SCHED_RR_EN
        if (win != '0) rr_d = (win == SW'(NUM_REQ - 1)) ? SW'(1) : win + SW'(1);
`endif
      end
    end
    mode_d = (state_q > DI_TRAIL) ? 3'd0 : (state_d == DI_PRE) ? 3'd4 :
             (state_d == DI_LEAD || state_d == DI_TRAIL) ? 3'd5 : (state_d == DI_DATA) ? 3'd6 : vmode;
  end
  always_ff @(posedge clk_pix or posedge rst_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      cnt_q <= '0;
      npkt_q <= '0;
      nsel_q <= '0;
      have_q <= 1'b0;
      mode <= '0;
      pkt_sel <= '0;
      pkt_cnt <= '0;
      grant <= '0;
`ifdef HDMI_SCHED_RR_EN
      rr_q <= SW'(1);
`endif
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      npkt_q <= npkt_d;
      nsel_q <= nsel_d;
      have_q <= have_d;
      mode <= mode_d;
      pkt_sel <= pkt_sel_d;
      pkt_cnt <= pkt_cnt_d;
      grant <= grant_d;
`ifdef HDMI_SCHED_RR_EN
      rr_q <= rr_d;
`endif
    end
  end
endmodule

// File: doc/hdmi_period_scheduler.md
Name: hdmi_period_scheduler

Overview:
- Pixel-rate sequencer for the HDMI TMDS path. Selects the period type for every pixel clock: control, video preamble/guard/data, or data-island preamble/guard/packet.
- Arbitrates packet requesters (ACR, audio sample, AVI InfoFrame, audio InfoFrame) into data islands placed in horizontal blanking.
- Sits between the cx/cy timing counters and the TMDS encoders/packet assembler.

Parameters:
- NUM_REQ, 4, number of packet requesters; index 0 has the highest fixed priority.
- ISLAND_START_X, 10, cx value at which a data island may begin on any line.
- MAX_PACKETS, 18, hard cap on packets per island.
- CTRL_MIN, 12, minimum control-period length before a video preamble.

Ports:
- clk_pix  in  1  pixel clock; the only clock.
- rst_in  in  1  reset, asynchronous, active-high.
- cx  in  10  current pixel x.
- cy  in  10  current pixel y.
- screen_start_x  in  10  first active x.
- screen_start_y  in  10  first active line.
- req  in  NUM_REQ  level packet requests.
- mode  out  3  0 ctrl, 1 vid_pre, 2 vid_guard, 3 vid_data, 4 di_pre, 5 di_guard, 6 di_data.
- pkt_sel  out  clog2(NUM_REQ)  requester owning the current packet.
- pkt_cnt  out  5  byte index 0..31 within the packet.
- grant  out  NUM_REQ  one-hot, one-cycle pulse.

Behaviour:
- Reset: mode=0, pkt_sel=0, pkt_cnt=0, grant=0, FSM=IDLE, island packet count=0. Reset asserted mid-island aborts the island; mode=0 on the next edge after release.
- Latency: all outputs are registered. mode at cycle t+1 reflects cx/cy sampled at t.
- Video timing, lines with cy>=screen_start_y:
  - vid_pre for cx in [screen_start_x-10, screen_start_x-3].
  - vid_guard for cx = screen_start_x-2 and screen_start_x-1.
  - vid_data for cx>=screen_start_x.
- Vertical-blanking lines: no video periods.
- Island budget: n_max = min(MAX_PACKETS, floor((screen_start_x - ISLAND_START_X - 22 - CTRL_MIN)/32)). Computed as signed; a negative or zero result means no island.
- FSM states: IDLE, DI_PRE (8 cycles), DI_LEAD (2), DI_DATA (32 per packet), DI_TRAIL (2), then back to IDLE.
- IDLE -> DI_PRE when cx==ISLAND_START_X, |req, and n_max>=1. Otherwise remain in IDLE; no island is started on that line.
- Arbitration: performed on the last DI_LEAD cycle and on pkt_cnt==31.
  - Winner = lowest set req index, with the next packet count < n_max.
  - The winner's grant bit pulses on that same cycle; pkt_sel latches it.
  - pkt_cnt resets to 0 on the first data cycle.
  - No winner at pkt_cnt==31 -> DI_TRAIL.
- Leading-guard requests: if req is deasserted during DI_LEAD so that no winner exists, emit one packet anyway with pkt_sel = previous winner and no grant. Verification checks that grant is 0 in this case.
- pkt_sel and pkt_cnt hold their values outside di_data.
- req is sampled only at arbitration points. Changes at other times have no effect.
- Placement guarantee: the n_max formula ensures DI_TRAIL completes at least CTRL_MIN cycles before vid_pre. There is no overlap case.
- Unreachable FSM states return to IDLE with mode=0.
- cx is not required to be monotonic. A jump mid-island does not shorten the island; the island completes from its internal counters.

Optional Feature:
- Macro: HDMI_SCHED_RR_EN.
- Defined: index 0 remains strict highest priority. Indices 1..NUM_REQ-1 are served round-robin; the pointer advances past each granted index and resets to 1.
- Undefined: pure fixed priority, lowest index wins.

Test Plan:
- 640x480 setup: screen_start_x=160, screen_start_y=45, req=4'b0010 held.
  - Expected: mode=4 for cx 10..17, 5 for 18..19, 6 for 20..115 (3 packets, grant[1] pulsed 3 times), 5 for 116..117, 0 for 118..149.
  - Then 1 for 150..157, 2 for 158..159, 3 for 160..799 on line 45.
- req=4'b1111 on a blanking line:
  - Fixed priority: pkt_sel 0,0,0.
  - With HDMI_SCHED_RR_EN and req[0] dropped after its first grant: pkt_sel 0,1,2.
- req=0 for a whole frame -> mode never 4/5/6, grant never pulses.
- screen_start_x=40 -> n_max<=0 -> no island even with req=4'b1111.
- rst_in pulsed at cx=30, mid-packet -> mode=0 during reset. The next island starts at the next line's cx=10.
- req[2] rising at cx=40, mid-packet, with no other requests -> ignored until pkt_cnt==31. Then grant[2] pulses and a second packet follows.
